// File: rtl/piso_bit_serializer_pkg.sv
// Shared definitions for the serializer and the downstream detectors that consume its stream.
package serial_pkg;

  // Legacy-compatible state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam int unsigned GAP_CNT_W        = 4;
  localparam bit          IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/piso_bit_serializer_if.sv
// Word-in / bit-out bus of the serializer; slave is the serializer side.
interface piso_bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x_out;
  logic             x_valid;
  logic             last_bit;
  logic             busy;

  modport master (output din, din_valid, input din_ready, x_out, x_valid, last_bit, busy);
  modport slave  (input din, din_valid, output din_ready, x_out, x_valid, last_bit, busy);
endinterface

// File: rtl/piso_bit_serializer_hold_buffer.sv
// One-entry word buffer: written on a transfer, emptied when moved into the shifter.
module piso_hold_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      full <= 1'b0;
    end else begin
      if (wr) data <= wdata;
      if (wr)      full <= 1'b1;
      else if (rd) full <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer and optional inter-word idle gap.
module piso_bit_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned GAP       = 0,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  piso_bit_serializer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP == 0) ? 0 : GAP - 1);

  logic [1:0]           state, state_n;
  logic [WIDTH-1:0]     shreg, shreg_n;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [GAP_CNT_W-1:0] gap_cnt, gap_cnt_n;
  logic                 x_out_n, x_valid_n, last_bit_n, busy_n;
  logic                 load_hold, load_din, wr_hold, hold_full_n;
  logic                 transfer;
  logic [WIDTH-1:0]     hold_data;
  logic                 hold_full;

  assign bus.din_ready = !hold_full && !rst;
  assign transfer      = bus.din_valid && bus.din_ready;

  piso_hold_buffer #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr_hold),
    .rd    (load_hold),
    .wdata (bus.din),
    .data  (hold_data),
    .full  (hold_full)
  );

  // Next state; a word end hands over to the buffer or a same-edge transfer without a bubble
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    load_hold = 1'b0;
    load_din  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (hold_full)     load_hold = 1'b1;
        else if (transfer) load_din  = 1'b1;
      end
      ST_SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
          if (GAP > 0) begin
            state_n   = ST_GAP;
            gap_cnt_n = '0;
          end else if (hold_full) begin
            load_hold = 1'b1;
          end else if (transfer) begin
            load_din = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          shreg_n   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
          bit_cnt_n = bit_cnt + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (hold_full)     load_hold = 1'b1;
          else if (transfer) load_din  = 1'b1;
          else               state_n   = ST_IDLE;
        end else begin
          gap_cnt_n = gap_cnt + GAP_CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (load_hold || load_din) begin
      shreg_n   = load_hold ? hold_data : bus.din;
      bit_cnt_n = '0;
      state_n   = ST_SHIFT;
    end

    wr_hold     = transfer && !load_din;
    hold_full_n = wr_hold || (hold_full && !load_hold);

    x_valid_n  = (state_n == ST_SHIFT);
    x_out_n    = x_valid_n ? (MSB_FIRST ? shreg_n[WIDTH-1] : shreg_n[0]) : IDLE_BIT;
    last_bit_n = x_valid_n && (bit_cnt_n == BIT_LAST);
    busy_n     = (state_n != ST_IDLE) || hold_full_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      bus.x_out    <= IDLE_BIT;
      bus.x_valid  <= 1'b0;
      bus.last_bit <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      state        <= state_n;
      shreg        <= shreg_n;
      bit_cnt      <= bit_cnt_n;
      gap_cnt      <= gap_cnt_n;
      bus.x_out    <= x_out_n;
      bus.x_valid  <= x_valid_n;
      bus.last_bit <= last_bit_n;
      bus.busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Self-checking bench: three serializer configurations checked against a word-schedule reference model.
module tb_piso_bit_serializer;

  localparam int W    = 8;
  localparam int NDUT = 3;
  localparam int MAXC = 512;

  // dut0: GAP=0 MSB-first idle 0; dut1: GAP=3 LSB-first idle 0; dut2: GAP=0 MSB-first idle 1
  function automatic int gap_of(input int d);
    return (d == 1) ? 3 : 0;
  endfunction
  function automatic bit msb_of(input int d);
    return (d != 1);
  endfunction
  function automatic bit idle_of(input int d);
    return (d == 2);
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] drv_din   [NDUT];
  logic         drv_valid [NDUT];
  logic         mon_ready [NDUT];
  logic         mon_x     [NDUT];
  logic         mon_v     [NDUT];
  logic         mon_l     [NDUT];
  logic         mon_b     [NDUT];

  piso_bit_serializer_if #(.WIDTH(W)) if0 ();
  piso_bit_serializer_if #(.WIDTH(W)) if1 ();
  piso_bit_serializer_if #(.WIDTH(W)) if2 ();

  assign if0.din = drv_din[0];  assign if0.din_valid = drv_valid[0];
  assign if1.din = drv_din[1];  assign if1.din_valid = drv_valid[1];
  assign if2.din = drv_din[2];  assign if2.din_valid = drv_valid[2];

  assign mon_ready[0] = if0.din_ready; assign mon_x[0] = if0.x_out; assign mon_v[0] = if0.x_valid;
  assign mon_l[0] = if0.last_bit;      assign mon_b[0] = if0.busy;
  assign mon_ready[1] = if1.din_ready; assign mon_x[1] = if1.x_out; assign mon_v[1] = if1.x_valid;
  assign mon_l[1] = if1.last_bit;      assign mon_b[1] = if1.busy;
  assign mon_ready[2] = if2.din_ready; assign mon_x[2] = if2.x_out; assign mon_v[2] = if2.x_valid;
  assign mon_l[2] = if2.last_bit;      assign mon_b[2] = if2.busy;

  piso_bit_serializer #(.WIDTH(W), .GAP(0), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  piso_bit_serializer #(.WIDTH(W), .GAP(3), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  piso_bit_serializer #(.WIDTH(W), .GAP(0), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1))
    dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] words_q [$];
  logic rec_v [MAXC];
  logic rec_x [MAXC];
  logic rec_l [MAXC];
  logic rec_b [MAXC];
  logic rec_r [MAXC];

  task automatic check_bit(input string name, input int d, input int cyc, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %b expected %b", name, d, cyc, act, exp);
    end
  endtask

  // Streams words_q into dut d with din_valid held, then compares every recorded cycle to the schedule model
  task automatic run_stream(input int d, input string name);
    int acc [$];
    int nw, span, k, n_end, idx;
    logic pv, pr;
    nw = words_q.size();
    span = W + gap_of(d);
    idx = 0; pv = 1'b0; pr = 1'b0; n_end = MAXC;
    for (int n = 0; n < MAXC; n++) begin
      @(negedge clk);
      if (pv && pr) begin
        acc.push_back(n);
        idx++;
      end
      rec_v[n] = mon_v[d]; rec_x[n] = mon_x[d]; rec_l[n] = mon_l[d];
      rec_b[n] = mon_b[d]; rec_r[n] = mon_ready[d];
      pr = mon_ready[d];
      pv = (idx < nw);
      drv_valid[d] = pv;
      drv_din[d]   = pv ? words_q[idx] : W'($urandom);
      if (acc.size() > 0 && n >= acc[0] + nw * span + 3) begin
        n_end = n + 1;
        break;
      end
    end
    drv_valid[d] = 1'b0;

    n_checks++;
    if (acc.size() != nw) begin
      n_fail++;
      $display("FAIL %s dut%0d accepted words: got %0d expected %0d", name, d, acc.size(), nw);
    end
    if (acc.size() == 0) return;
    k = acc[0];

    for (int m = 1; m < acc.size(); m++) begin
      n_checks++;
      if (acc[m] != k + (m - 1) * span + 1) begin
        n_fail++;
        $display("FAIL %s dut%0d accept edge of word %0d: got %0d expected %0d",
                 name, d, m, acc[m] - k, (m - 1) * span + 1);
      end
    end

    for (int c = 0; c < n_end; c++) begin
      int rel, j, wi;
      logic ev, ex, el, eb, er;
      logic [W-1:0] word;
      rel = c - k;
      ev = 1'b0; el = 1'b0; eb = 1'b0; er = 1'b1;
      ex = idle_of(d);
      if (rel >= 0 && rel < nw * span) begin
        eb = 1'b1;
        j  = rel % span;
        wi = rel / span;
        if (j < W) begin
          word = words_q[wi];
          ev = 1'b1;
          ex = msb_of(d) ? word[W-1-j] : word[j];
          el = (j == W - 1);
        end
      end
      for (int m = 1; m < nw; m++)
        if (c >= k + (m - 1) * span + 1 && c < k + m * span) er = 1'b0;
      check_bit({name, " x_valid"},   d, c - k, rec_v[c], ev);
      check_bit({name, " x_out"},     d, c - k, rec_x[c], ex);
      check_bit({name, " last_bit"},  d, c - k, rec_l[c], el);
      check_bit({name, " busy"},      d, c - k, rec_b[c], eb);
      check_bit({name, " din_ready"}, d, c - k, rec_r[c], er);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      drv_valid[d] = 1'b0;
      drv_din[d]   = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check_bit("reset x_out",     d, 0, mon_x[d], idle_of(d));
      check_bit("reset x_valid",   d, 0, mon_v[d], 1'b0);
      check_bit("reset last_bit",  d, 0, mon_l[d], 1'b0);
      check_bit("reset busy",      d, 0, mon_b[d], 1'b0);
      check_bit("reset din_ready", d, 0, mon_ready[d], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++)
      check_bit("post-reset din_ready", d, 0, mon_ready[d], 1'b1);
  endtask

  task automatic test_single_word();
    words_q = '{8'hB4};
    run_stream(0, "single");
  endtask

  task automatic test_back_to_back();
    words_q = '{8'hFF, 8'h00};
    run_stream(0, "b2b");
  endtask

  task automatic test_gap();
    words_q = '{8'h01, 8'h80};
    run_stream(1, "gap");
  endtask

  task automatic test_backpressure();
    words_q = '{8'hAA, 8'h55, W'($urandom)};
    run_stream(0, "backpressure");
  endtask

  task automatic test_async_reset();
    logic [W-1:0] w;
    w = 8'hC3;
    @(negedge clk);
    check_bit("areset idle ready", 0, 0, mon_ready[0], 1'b1);
    drv_din[0] = w; drv_valid[0] = 1'b1;
    @(negedge clk);
    drv_din[0] = 8'h5A;
    @(negedge clk);
    drv_valid[0] = 1'b0;
    check_bit("areset hold full", 0, 1, mon_ready[0], 1'b0);
    repeat (2) @(negedge clk);
    check_bit("areset bit3 valid", 0, 3, mon_v[0], 1'b1);
    check_bit("areset bit3 value", 0, 3, mon_x[0], w[W-4]);
    #1 rst = 1'b1;
    #1;
    check_bit("areset x_valid",   0, 3, mon_v[0], 1'b0);
    check_bit("areset din_ready", 0, 3, mon_ready[0], 1'b0);
    check_bit("areset busy",      0, 3, mon_b[0], 1'b0);
    check_bit("areset last_bit",  0, 3, mon_l[0], 1'b0);
    check_bit("areset x_out",     0, 3, mon_x[0], 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_bit("areset release busy",  0, 0, mon_b[0], 1'b0);
    check_bit("areset release valid", 0, 0, mon_v[0], 1'b0);
    words_q = '{8'h0F};
    run_stream(0, "after-reset");
  endtask

  task automatic test_idle_level();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drv_din[2] = W'($urandom);
      check_bit("idle x_out",   2, c, mon_x[2], 1'b1);
      check_bit("idle x_valid", 2, c, mon_v[2], 1'b0);
    end
    words_q = '{8'h00};
    run_stream(2, "idle-level");
  endtask

  task automatic test_random();
    for (int d = 0; d < NDUT; d++) begin
      int cnt;
      cnt = int'($urandom_range(6, 3));
      words_q.delete();
      for (int i = 0; i < cnt; i++) words_q.push_back(W'($urandom));
      run_stream(d, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_gap();
    test_backpressure();
    test_async_reset();
    test_idle_level();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
